// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM encoding and address-field helpers for the data cache
package dcache_pkg;
  localparam int SETS = 64;
  localparam int TAG_W = 9;
  localparam int ADDR_W = 18;
  localparam int INDEX_W = $clog2(SETS);
  localparam int OFFSET = 3;
  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET +: INDEX_W];
  endfunction
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[OFFSET+INDEX_W +: TAG_W];
  endfunction
  function automatic logic addr_word(input logic [ADDR_W-1:0] a);
    return a[2];
  endfunction
  function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: MEM-stage request bus and SRAM-controller bus of the data cache
interface dcache_if;
  import dcache_pkg::*;
  logic [31:0] address;
  logic [31:0] wdata;
  logic mem_r_en;
  logic mem_w_en;
  logic [31:0] rdata;
  logic ready;
  logic [ADDR_W-1:0] sram_address;
  logic [31:0] sram_wdata;
  logic sram_r_en;
  logic sram_w_en;
  logic [63:0] sram_rdata;
  logic sram_ready;
  modport slave(input address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
                output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en);
  modport master(output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
                 input rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en);
endinterface

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache (valid/tag/64-bit block per set) with fill and word-update ports
module dcache_way
  import dcache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  input  logic i_word,
  input  logic i_fill_en,
  input  logic [63:0] i_fill_data,
  input  logic i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic o_hit,
  output logic o_valid,
  output logic [31:0] o_rdata
);
  logic [SETS-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [SETS];
  logic [63:0] r_data [SETS];
  // valid bits clear on reset; a fill marks the line valid
  always_ff @(posedge clock or posedge reset)
    if (reset) r_valid <= '0;
    else if (i_fill_en) r_valid[i_index] <= 1'b1;
  // fill replaces tag and whole block; a store hit patches only the addressed word
  always_ff @(posedge clock)
    if (i_fill_en) begin
      r_tag[i_index] <= i_tag;
      r_data[i_index] <= i_fill_data;
    end else if (i_wr_en)
      r_data[i_index] <= i_word ? {i_wr_data, r_data[i_index][31:0]} : {r_data[i_index][63:32], i_wr_data};
  assign o_valid = r_valid[i_index];
  assign o_hit = r_valid[i_index] && r_tag[i_index] == i_tag;
  assign o_rdata = i_word ? r_data[i_index][63:32] : r_data[i_index][31:0];
endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: 2-way write-through no-write-allocate data cache; DCACHE_STATS_EN adds hit/miss counters
module data_cache_ctrl
  import dcache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  state_t r_state, w_next;
  logic [SETS-1:0] r_lru;
  logic [ADDR_W-1:0] w_addr;
  logic [INDEX_W-1:0] w_index;
  logic w_word, w_rd, w_wr, w_hit0, w_hit1, w_hit, w_valid0, w_valid1, w_victim, w_fill, w_upd;
  logic [31:0] w_data0, w_data1;
  logic w_unused_addr;
  assign w_unused_addr = ^bus.address[31:ADDR_W];
  assign w_addr = bus.address[ADDR_W-1:0];
  assign w_index = addr_index(w_addr);
  assign w_word = addr_word(w_addr);
  assign w_wr = bus.mem_w_en;
  assign w_rd = bus.mem_r_en && !bus.mem_w_en;
  assign w_hit = w_hit0 || w_hit1;
  assign w_victim = !w_valid0 ? 1'b0 : !w_valid1 ? 1'b1 : r_lru[w_index];
  assign w_upd = r_state == IDLE && w_wr && w_hit;
  dcache_way u_way0 (
    .clock(clock), .reset(reset), .i_index(w_index), .i_tag(addr_tag(w_addr)), .i_word(w_word),
    .i_fill_en(w_fill && !w_victim), .i_fill_data(bus.sram_rdata), .i_wr_en(w_upd && w_hit0),
    .i_wr_data(bus.wdata), .o_hit(w_hit0), .o_valid(w_valid0), .o_rdata(w_data0)
  );
  dcache_way u_way1 (
    .clock(clock), .reset(reset), .i_index(w_index), .i_tag(addr_tag(w_addr)), .i_word(w_word),
    .i_fill_en(w_fill && w_victim), .i_fill_data(bus.sram_rdata), .i_wr_en(w_upd && w_hit1),
    .i_wr_data(bus.wdata), .o_hit(w_hit1), .o_valid(w_valid1), .o_rdata(w_data1)
  );
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // LRU points away from the way just hit or filled
  always_ff @(posedge clock or posedge reset)
    if (reset) r_lru <= '0;
    else if (w_fill) r_lru[w_index] <= !w_victim;
    else if (r_state == IDLE && (w_rd || w_wr) && w_hit) r_lru[w_index] <= w_hit0;
  // next state, handshake and read-data mux
  always_comb begin
    w_next = r_state;
    w_fill = 1'b0;
    bus.ready = 1'b1;
    bus.rdata = '0;
    bus.sram_r_en = 1'b0;
    bus.sram_w_en = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_wr ? WRITE : (w_rd && !w_hit) ? READ_MISS : IDLE;
        bus.ready = !w_wr && !(w_rd && !w_hit);
        bus.rdata = (w_rd && w_hit) ? (w_hit0 ? w_data0 : w_data1) : '0;
      end
      READ_MISS: begin
        w_next = bus.sram_ready ? IDLE : READ_MISS;
        w_fill = bus.sram_ready;
        bus.ready = bus.sram_ready;
        bus.rdata = !bus.sram_ready ? '0 : w_word ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
        bus.sram_r_en = 1'b1;
      end
      WRITE: begin
        w_next = bus.sram_ready ? IDLE : WRITE;
        bus.ready = bus.sram_ready;
        bus.sram_w_en = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  assign bus.sram_address = r_state == READ_MISS ? block_addr(w_addr) : w_addr;
  assign bus.sram_wdata = bus.wdata;
  a_rw_exclusive: assert property (@(posedge clock) disable iff (reset) !(bus.mem_r_en && bus.mem_w_en));
`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;
  // saturating load hit/miss counters sampled in IDLE
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_hit_count <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == IDLE && w_rd && w_hit && ~&r_hit_count) r_hit_count <= r_hit_count + 32'd1;
      if (r_state == IDLE && w_rd && !w_hit && ~&r_miss_count) r_miss_count <= r_miss_count + 32'd1;
    end
  assign hit_count = r_hit_count;
  assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: directed vector table plus reset-mid-miss sequence for data_cache_ctrl
module tb_data_cache_ctrl;
  logic clock = 1'b0;
  logic reset;
  int n_pass = 0;
  int n_total = 0;
  logic saw_r, saw_w;
  logic [17:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] got_rdata;
  int got_cyc;
  dcache_if bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  data_cache_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 clock = ~clock;
  typedef struct {
    logic r;
    logic w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] blk;
    logic [31:0] exp_rdata;
    int exp_cyc;
    logic exp_sr;
    logic exp_sw;
    logic [17:0] exp_saddr;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [63:0] blk);
    @(negedge clock);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address = a;
    bus.wdata = d;
    bus.sram_ready = 1'b0;
    saw_r = 1'b0;
    saw_w = 1'b0;
    cap_addr = '0;
    cap_wdata = '0;
    got_cyc = 0;
    #1;
    while (!bus.ready && got_cyc < 20) begin
      if (bus.sram_r_en || bus.sram_w_en) begin
        cap_addr = bus.sram_address;
        cap_wdata = bus.sram_wdata;
      end
      saw_r |= bus.sram_r_en;
      saw_w |= bus.sram_w_en;
      @(negedge clock);
      got_cyc++;
      if (got_cyc >= 2) begin
        bus.sram_ready = 1'b1;
        bus.sram_rdata = blk;
      end
      #1;
    end
    saw_r |= bus.sram_r_en;
    saw_w |= bus.sram_w_en;
    got_rdata = bus.rdata;
    chk("req_ready", {63'd0, bus.ready}, 64'd1);
    @(posedge clock);
    #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.sram_ready = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{1, 0, 32'h400,  0, 64'h2222_0000_1111_0000, 32'h1111_0000, 2, 1, 0, 18'h400};
    vecs[1]  = '{1, 0, 32'h404,  0, 64'h0,                   32'h2222_0000, 0, 0, 0, 18'h0};
    vecs[2]  = '{1, 0, 32'h208,  0, 64'hA1A1_A1A1_A0A0_A0A0, 32'hA0A0_A0A0, 2, 1, 0, 18'h208};
    vecs[3]  = '{1, 0, 32'h40C,  0, 64'hB1B1_B1B1_B0B0_B0B0, 32'hB1B1_B1B1, 2, 1, 0, 18'h408};
    vecs[4]  = '{1, 0, 32'h20C,  0, 64'h0,                   32'hA1A1_A1A1, 0, 0, 0, 18'h0};
    vecs[5]  = '{1, 0, 32'h608,  0, 64'hC1C1_C1C1_C0C0_C0C0, 32'hC0C0_C0C0, 2, 1, 0, 18'h608};
    vecs[6]  = '{1, 0, 32'h208,  0, 64'h0,                   32'hA0A0_A0A0, 0, 0, 0, 18'h0};
    vecs[7]  = '{1, 0, 32'h408,  0, 64'hB1B1_B1B1_B0B0_B0B0, 32'hB0B0_B0B0, 2, 1, 0, 18'h408};
    vecs[8]  = '{0, 1, 32'h400,  32'hDEAD_BEEF, 64'h0,       32'h0,         2, 0, 1, 18'h400};
    vecs[9]  = '{1, 0, 32'h400,  0, 64'h0,                   32'hDEAD_BEEF, 0, 0, 0, 18'h0};
    vecs[10] = '{1, 0, 32'h404,  0, 64'h0,                   32'h2222_0000, 0, 0, 0, 18'h0};
    vecs[11] = '{0, 1, 32'h1000, 32'h1234_5678, 64'h0,       32'h0,         2, 0, 1, 18'h1000};
    vecs[12] = '{1, 0, 32'h1000, 0, 64'h5555_5555_1234_5678, 32'h1234_5678, 2, 1, 0, 18'h1000};
    vecs[13] = '{1, 0, 32'h20C,  0, 64'h0,                   32'hA1A1_A1A1, 0, 0, 0, 18'h0};
    reset = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address = '0;
    bus.wdata = '0;
    bus.sram_rdata = '0;
    bus.sram_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_ready", {63'd0, bus.ready}, 64'd1);
    chk("rst_sram_r_en", {63'd0, bus.sram_r_en}, 64'd0);
    chk("rst_sram_w_en", {63'd0, bus.sram_w_en}, 64'd0);
    chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      req(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].blk);
      chk($sformatf("v%0d_cycles", i), 64'(got_cyc), 64'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_sram_r_en", i), {63'd0, saw_r}, {63'd0, vecs[i].exp_sr});
      chk($sformatf("v%0d_sram_w_en", i), {63'd0, saw_w}, {63'd0, vecs[i].exp_sw});
      if (vecs[i].r) chk($sformatf("v%0d_rdata", i), {32'd0, got_rdata}, {32'd0, vecs[i].exp_rdata});
      if (vecs[i].exp_sr || vecs[i].exp_sw)
        chk($sformatf("v%0d_sram_addr", i), {46'd0, cap_addr}, {46'd0, vecs[i].exp_saddr});
      if (vecs[i].w) chk($sformatf("v%0d_sram_wdata", i), {32'd0, cap_wdata}, {32'd0, vecs[i].wdata});
    end
    @(negedge clock);
    bus.mem_r_en = 1'b1;
    bus.address = 32'h808;
    repeat (2) @(negedge clock);
    #1;
    chk("miss_ready", {63'd0, bus.ready}, 64'd0);
    chk("miss_sram_r_en", {63'd0, bus.sram_r_en}, 64'd1);
    reset = 1'b1;
    bus.mem_r_en = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, bus.ready}, 64'd1);
    chk("midrst_sram_r_en", {63'd0, bus.sram_r_en}, 64'd0);
    chk("midrst_rdata", {32'd0, bus.rdata}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    req(1'b1, 1'b0, 32'h400, 32'h0, 64'h7777_0000_6666_0000);
    chk("post_rst_cycles", 64'(got_cyc), 64'd2);
    chk("post_rst_sram_r_en", {63'd0, saw_r}, 64'd1);
    chk("post_rst_rdata", {32'd0, got_rdata}, 64'h6666_0000);
    req(1'b1, 1'b0, 32'h404, 32'h0, 64'h0);
    chk("post_rst_hit_cycles", 64'(got_cyc), 64'd0);
    chk("post_rst_hit_rdata", {32'd0, got_rdata}, 64'h7777_0000);
`ifdef DCACHE_STATS_EN
    chk("miss_count", {32'd0, miss_count}, 64'd1);
    chk("hit_count", {32'd0, hit_count}, 64'd1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
